vec_strip_seq: RTL and testbench

Strip-mining sequencer that consumes a vector configuration: the total application vector length (AVL), the element width (SEW) and the register-group multiplier (LMUL). It repeatedly computes `vl = min(VLMAX, remaining AVL)` and issues one element-index beat per element of each strip over a valid/ready stream. It is the consumer counterpart of the vl-setup logic and sits between instruction decode and the vector element datapath.

---
 rtl/vec_pkg.sv | 59 +++++
 rtl/vec_vlmax_calc.sv | 32 +++
 rtl/vec_strip_seq.sv | 162 ++++++++++++++++
 tb/tb_vec_strip_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector strip-mining sequencer.
package vec_pkg;

  localparam int unsigned VLEN_DEFAULT = 64;
  localparam int unsigned CNT_W        = 9;
  localparam int unsigned SEW_W        = 7;
  localparam int unsigned LMUL_W       = 5;
  localparam int unsigned SHIFT_W      = 3;

  localparam logic [SEW_W-1:0] SEW_E4  = SEW_W'(4);
  localparam logic [SEW_W-1:0] SEW_E8  = SEW_W'(8);
  localparam logic [SEW_W-1:0] SEW_E16 = SEW_W'(16);
  localparam logic [SEW_W-1:0] SEW_E32 = SEW_W'(32);
  localparam logic [SEW_W-1:0] SEW_E64 = SEW_W'(64);

  localparam logic [LMUL_W-1:0] LMUL_M1  = LMUL_W'(1);
  localparam logic [LMUL_W-1:0] LMUL_M2  = LMUL_W'(2);
  localparam logic [LMUL_W-1:0] LMUL_M4  = LMUL_W'(4);
  localparam logic [LMUL_W-1:0] LMUL_M8  = LMUL_W'(8);
  localparam logic [LMUL_W-1:0] LMUL_M16 = LMUL_W'(16);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_DONE
  } strip_state_t;

  typedef struct packed {
    logic               illegal;
    logic [SHIFT_W-1:0] shift;
  } sew_dec_t;

  // Decode a literal SEW into its log2 shift, flagging unsupported widths.
  function automatic sew_dec_t log2_sew(input logic [SEW_W-1:0] sew);
    sew_dec_t d;
    d.illegal = 1'b0;
    d.shift   = '0;
    case (sew)
      SEW_E4:  d.shift = SHIFT_W'(2);
      SEW_E8:  d.shift = SHIFT_W'(3);
      SEW_E16: d.shift = SHIFT_W'(4);
      SEW_E32: d.shift = SHIFT_W'(5);
      SEW_E64: d.shift = SHIFT_W'(6);
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic lmul_illegal(input logic [LMUL_W-1:0] lmul);
    logic bad;
    case (lmul)
      LMUL_M1, LMUL_M2, LMUL_M4, LMUL_M8, LMUL_M16: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational strip length: vl = min(VLMAX(sew, lmul), rem) and the remainder after it.
module vec_vlmax_calc
  import vec_pkg::*;
#(
  parameter int unsigned VLEN = VLEN_DEFAULT
) (
  input  logic [SEW_W-1:0]  sew,
  input  logic [LMUL_W-1:0] lmul,
  input  logic [CNT_W-1:0]  rem,
  output logic [CNT_W-1:0]  vl,
  output logic [CNT_W-1:0]  rem_next,
  output logic              illegal
);

  localparam int unsigned PROD_W = 32;

  sew_dec_t          dec;
  logic [PROD_W-1:0] vlmax;

  // VLMAX is formed wide so larger VLEN values cannot alias before the min.
  always_comb begin
    dec     = log2_sew(sew);
    illegal = dec.illegal | lmul_illegal(lmul);
    vlmax   = (PROD_W'(VLEN) >> dec.shift) * PROD_W'(lmul);
    vl      = '0;
    if (!illegal) begin
      vl = (vlmax < PROD_W'(rem)) ? vlmax[CNT_W-1:0] : rem;
    end
    rem_next = rem - vl;
  end

endmodule

// File: rtl/vec_strip_seq.sv
// Strip-mining sequencer: splits an AVL into VLMAX-sized strips and issues one beat per element.
// Optional VEC_STRIP_STATS_EN adds a per-command strip counter output.
module vec_strip_seq
  import vec_pkg::*;
#(
  parameter int unsigned VLEN = VLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_avl,
  input  logic [SEW_W-1:0]  cmd_sew,
  input  logic [LMUL_W-1:0] cmd_lmul,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [CNT_W-1:0]  elem_idx,
  output logic [CNT_W-1:0]  elem_base,
  output logic              elem_last_strip,
  output logic              elem_last,
  output logic [CNT_W-1:0]  strip_vl,
`ifdef VEC_STRIP_STATS_EN
  output logic [CNT_W-1:0]  strip_cnt,
`endif
  output logic              done,
  output logic              err
);

  strip_state_t      state, state_n;
  logic [CNT_W-1:0]  rem, rem_n;
  logic [SEW_W-1:0]  sew_q, sew_n;
  logic [LMUL_W-1:0] lmul_q, lmul_n;
  logic [CNT_W-1:0]  base_n, idx_n, vl_n;
  logic              err_flag, err_flag_n;
  logic              issue_n, last_strip_n, last_n;

  logic [CNT_W-1:0]  calc_vl, calc_rem_next;
  logic              calc_illegal;

  vec_vlmax_calc #(
    .VLEN (VLEN)
  ) u_vlmax_calc (
    .sew      (sew_q),
    .lmul     (lmul_q),
    .rem      (rem),
    .vl       (calc_vl),
    .rem_next (calc_rem_next),
    .illegal  (calc_illegal)
  );

  // Next-state and next-output decode; beat outputs are registered from these.
  always_comb begin
    state_n    = state;
    rem_n      = rem;
    sew_n      = sew_q;
    lmul_n     = lmul_q;
    base_n     = elem_base;
    idx_n      = elem_idx;
    vl_n       = strip_vl;
    err_flag_n = err_flag;

    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          rem_n   = cmd_avl;
          sew_n   = cmd_sew;
          lmul_n  = cmd_lmul;
          base_n  = '0;
          state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (calc_illegal) begin
          err_flag_n = 1'b1;
          state_n    = ST_DONE;
        end else if (rem == '0) begin
          state_n = ST_DONE;
        end else begin
          vl_n    = calc_vl;
          rem_n   = calc_rem_next;
          idx_n   = '0;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (elem_ready) begin
          idx_n = elem_idx + CNT_W'(1);
          if (elem_last_strip) begin
            base_n  = elem_base + strip_vl;
            state_n = (rem == '0) ? ST_DONE : ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        err_flag_n = 1'b0;
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    issue_n      = (state_n == ST_ISSUE);
    last_strip_n = issue_n && (idx_n == (vl_n - CNT_W'(1)));
    last_n       = last_strip_n && (rem_n == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      rem             <= '0;
      sew_q           <= '0;
      lmul_q          <= '0;
      err_flag        <= 1'b0;
      cmd_ready       <= 1'b1;
      elem_valid      <= 1'b0;
      elem_idx        <= '0;
      elem_base       <= '0;
      elem_last_strip <= 1'b0;
      elem_last       <= 1'b0;
      strip_vl        <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= state_n;
      rem             <= rem_n;
      sew_q           <= sew_n;
      lmul_q          <= lmul_n;
      err_flag        <= err_flag_n;
      cmd_ready       <= (state_n == ST_IDLE);
      elem_valid      <= issue_n;
      elem_idx        <= idx_n;
      elem_base       <= base_n;
      elem_last_strip <= last_strip_n;
      elem_last       <= last_n;
      strip_vl        <= vl_n;
      done            <= (state_n == ST_DONE);
      err             <= (state_n == ST_DONE) && err_flag_n;
    end
  end

`ifdef VEC_STRIP_STATS_EN
  logic [CNT_W-1:0] strip_cnt_n;

  // Strip counter: cleared on accept, bumped on every SETUP->ISSUE.
  always_comb begin
    strip_cnt_n = strip_cnt;
    if ((state == ST_IDLE) && cmd_valid) begin
      strip_cnt_n = '0;
    end else if ((state == ST_SETUP) && (state_n == ST_ISSUE)) begin
      strip_cnt_n = strip_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strip_cnt <= '0;
    end else begin
      strip_cnt <= strip_cnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_vec_strip_seq.sv
// Scoreboard bench for vec_strip_seq: stimulus queues expected beats/completions, a monitor checks them.
module tb_vec_strip_seq;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_avl;
  logic [6:0] cmd_sew;
  logic [4:0] cmd_lmul;
  logic       elem_valid;
  logic       elem_ready;
  logic [8:0] elem_idx;
  logic [8:0] elem_base;
  logic       elem_last_strip;
  logic       elem_last;
  logic [8:0] strip_vl;
  logic       done;
  logic       err;
`ifdef VEC_STRIP_STATS_EN
  logic [8:0] strip_cnt;
`endif

  vec_strip_seq #(.VLEN(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_avl         (cmd_avl),
    .cmd_sew         (cmd_sew),
    .cmd_lmul        (cmd_lmul),
    .elem_valid      (elem_valid),
    .elem_ready      (elem_ready),
    .elem_idx        (elem_idx),
    .elem_base       (elem_base),
    .elem_last_strip (elem_last_strip),
    .elem_last       (elem_last),
    .strip_vl        (strip_vl),
`ifdef VEC_STRIP_STATS_EN
    .strip_cnt       (strip_cnt),
`endif
    .done            (done),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] idx;
    logic [8:0] base;
    logic [8:0] vl;
    logic       ls;
    logic       l;
  } beat_t;

  beat_t beat_q[$];
  bit    done_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_elem_valid"}, 32'(elem_valid), 32'd0);
    chk({tag, "_idx_base_vl"}, {5'd0, elem_idx, elem_base, strip_vl}, 32'd0);
    chk({tag, "_lasts"}, 32'({elem_last_strip, elem_last}), 32'd0);
    chk({tag, "_done_err"}, 32'({done, err}), 32'd0);
`ifdef VEC_STRIP_STATS_EN
    chk({tag, "_strip_cnt"}, 32'(strip_cnt), 32'd0);
`endif
  endtask

  // Monitor: beats are compared against the queue head, popped on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (elem_valid) begin
        if (beat_q.size() == 0) begin
          chk("spurious_beat", 32'(elem_idx), 32'h1ff);
        end else begin
          chk("beat{idx,base,vl,ls,l}",
              32'({elem_idx, elem_base, strip_vl, elem_last_strip, elem_last}),
              32'(beat_q[0]));
          if (elem_ready) void'(beat_q.pop_front());
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else chk("done_err", 32'(err), 32'(done_q.pop_front()));
        chk("beats_left_at_done", 32'(beat_q.size()), 32'd0);
      end else if (err) begin
        chk("err_without_done", 32'd1, 32'd0);
      end
    end
  end

  // Issue one command and track it to completion (or abort it with reset at abort_at).
  task automatic run_cmd(input int avl, input int sew, input int lmul, input int vlmax,
                         input bit exp_err, input int exp_lat, input int exp_strips,
                         input int stall_lo, input int stall_hi,
                         input int abort_at, input int abort_pending);
    int  lat;
    int  rem;
    int  base;
    int  vl;
    bit  finished;
    beat_t b;

    rem  = exp_err ? 0 : avl;
    base = 0;
    while (rem > 0) begin
      vl  = (vlmax < rem) ? vlmax : rem;
      rem = rem - vl;
      for (int i = 0; i < vl; i++) begin
        b.idx  = 9'(i);
        b.base = 9'(base);
        b.vl   = 9'(vl);
        b.ls   = (i == vl - 1);
        b.l    = (i == vl - 1) && (rem == 0);
        beat_q.push_back(b);
      end
      base = base + vl;
    end
    done_q.push_back(exp_err);

    @(posedge clk); #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_avl   = 9'(avl);
    cmd_sew   = 7'(sew);
    cmd_lmul  = 5'(lmul);
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    lat      = 1;
    finished = 1'b0;
    while (!finished) begin
      @(negedge clk);
      if (lat == 1) chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      if (done) begin
        chk("done_cycle", 32'(lat), 32'(exp_lat));
`ifdef VEC_STRIP_STATS_EN
        chk("strip_cnt", 32'(strip_cnt), 32'(exp_strips));
`endif
        finished = 1'b1;
      end else if (lat >= 1000) begin
        chk("done_timeout", 32'(lat), 32'(exp_lat));
        finished = 1'b1;
      end else begin
        @(posedge clk); #1;
        lat++;
        elem_ready = !((stall_lo != 0) && (lat >= stall_lo) && (lat <= stall_hi));
        if ((abort_at != 0) && (lat == abort_at)) begin
          rst_n = 1'b0;
          #1;
          chk_reset_vals("abort");
          chk("beats_pending_at_abort", 32'(beat_q.size()), 32'(abort_pending));
          beat_q.delete();
          done_q.delete();
          @(posedge clk); #1;
          rst_n = 1'b1;
          finished = 1'b1;
        end
      end
    end

    elem_ready = 1'b1;
    if (abort_at == 0) begin
      @(negedge clk);
      chk("ready_after_done", 32'({cmd_ready, done}), 32'b10);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_avl    = '0;
    cmd_sew    = '0;
    cmd_lmul   = '0;
    elem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    //      avl  sew lmul vlmax err lat  strips stall   abort pend
    run_cmd(40,  8,  2,   16,   0,  44,  3,     0, 0,   0,  0);  // three strips 16/16/8
    run_cmd(3,   64, 1,   1,    0,  7,   3,     0, 0,   0,  0);  // strips of one
    run_cmd(0,   32, 4,   32,   0,  2,   0,     0, 0,   0,  0);  // AVL=0
    run_cmd(10,  12, 1,   0,    1,  2,   0,     0, 0,   0,  0);  // illegal SEW
    run_cmd(7,   8,  3,   0,    1,  2,   0,     0, 0,   0,  0);  // illegal LMUL
    run_cmd(4,   16, 1,   4,    0,  9,   1,     4, 6,   0,  0);  // back-pressure at idx 2
    run_cmd(20,  8,  1,   8,    0,  0,   0,     0, 0,   14, 9);  // reset mid strip 2, idx 3
    run_cmd(5,   8,  1,   8,    0,  7,   1,     0, 0,   0,  0);  // recovery command
    run_cmd(16,  4,  1,   16,   0,  18,  1,     0, 0,   0,  0);  // AVL exactly VLMAX
    run_cmd(511, 4,  16,  256,  0,  514, 2,     0, 0,   0,  0);  // max strips 256/255

    repeat (3) @(posedge clk);
    chk("queues_drained", 32'(beat_q.size() + done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
